// File: rtl/vga_timing_generator.sv
// vga_timing_generator: free-running 640x480@60Hz raster timing from the 25 MHz pixel clock.
// Optional per-frame counter output (frameCount) when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       hSync,
  output logic       vSync,
  output logic       active,
  output logic       screenEnd,
  output logic [9:0] x,
  output logic [8:0] y
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0] frameCount
`endif
);
  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic       h_end;
  always_comb begin
    h_end    = hcount_q == 10'(H_TOTAL - 1);
    hcount_d = h_end ? '0 : hcount_q + 10'd1;
    vcount_d = !h_end ? vcount_q : (vcount_q == 10'(V_TOTAL - 1)) ? '0 : vcount_q + 10'd1;
  end
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end
  // Every output is a pure decode of the counters, so reset forces them immediately.
  assign active    = (hcount_q < 10'(WIDTH)) && (vcount_q < 10'(HEIGHT));
  assign hSync     = !((hcount_q >= 10'(WIDTH + H_FRONT)) && (hcount_q < 10'(WIDTH + H_FRONT + H_SYNC)));
  assign vSync     = !((vcount_q >= 10'(HEIGHT + V_FRONT)) && (vcount_q < 10'(HEIGHT + V_FRONT + V_SYNC)));
  assign screenEnd = (hcount_q == '0) && (vcount_q == 10'(HEIGHT));
  assign x         = active ? hcount_q : '0;
  assign y         = active ? vcount_q[8:0] : '0;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = screenEnd ? frame_cnt_q + 8'd1 : frame_cnt_q;
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end
  assign frameCount = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: checks a full-size and a shrunken-timing instance against an arithmetic raster model.
module tb_vga_timing_generator;
  localparam int SW = 8, SHF = 2, SHS = 3, SHB = 2, SH = 4, SVF = 1, SVS = 2, SVB = 1;
  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk25 = ~clk25;
  logic       hs_a, vs_a, act_a, se_a, hs_b, vs_b, act_b, se_b;
  logic [9:0] x_a, x_b;
  logic [8:0] y_a, y_b;
  logic [7:0] fc_a, fc_b;
  vga_timing_generator dut (
    .clk25(clk25), .reset(rst_n), .hSync(hs_a), .vSync(vs_a), .active(act_a),
    .screenEnd(se_a), .x(x_a), .y(y_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frameCount(fc_a)
`endif
  );
  vga_timing_generator #(
    .WIDTH(SW), .HEIGHT(SH), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .clk25(clk25), .reset(rst_n), .hSync(hs_b), .vSync(vs_b), .active(act_b),
    .screenEnd(se_b), .x(x_b), .y(y_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frameCount(fc_b)
`endif
  );
`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc_a = '0;
  assign fc_b = '0;
`endif
  typedef struct {
    logic       hs, vs, act, se;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] fc;
  } out_t;
  typedef struct {
    int         cyc;
    bit         s;
    logic [9:0] x;
    logic [8:0] y;
    logic       act, hs, vs, se;
  } vec_t;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  // Expected outputs n cycles after reset release, straight from the raster rules.
  function automatic out_t model(int w, int hf, int hs, int hb, int h, int vf, int vs, int vb, int k);
    out_t m;
    int ht, vt, hc, vc;
    ht = w + hf + hs + hb;
    vt = h + vf + vs + vb;
    hc = k % ht;
    vc = (k / ht) % vt;
    m.act = (hc < w) && (vc < h);
    m.x   = m.act ? 10'(hc) : '0;
    m.y   = m.act ? 9'(vc) : '0;
    m.hs  = !((hc >= w + hf) && (hc < w + hf + hs));
    m.vs  = !((vc >= h + vf) && (vc < h + vf + vs));
    m.se  = (hc == 0) && (vc == h);
    m.fc  = (k > h * ht) ? 8'((k - h * ht - 1) / (ht * vt) + 1) : '0;
    return m;
  endfunction
  function automatic out_t get(bit s);
    out_t g;
    g.hs  = s ? hs_b : hs_a;
    g.vs  = s ? vs_b : vs_a;
    g.act = s ? act_b : act_a;
    g.se  = s ? se_b : se_a;
    g.x   = s ? x_b : x_a;
    g.y   = s ? y_b : y_a;
    g.fc  = s ? fc_b : fc_a;
    return g;
  endfunction
  task automatic cmp(string nm, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s at n=%0d: got %0d expected %0d", nm, n, got, exp);
    end
  endtask
  task automatic check(string tag, out_t g, out_t e);
    cmp({tag, ".hSync"}, g.hs, e.hs);
    cmp({tag, ".vSync"}, g.vs, e.vs);
    cmp({tag, ".active"}, g.act, e.act);
    cmp({tag, ".screenEnd"}, g.se, e.se);
    cmp({tag, ".x"}, g.x, e.x);
    cmp({tag, ".y"}, g.y, e.y);
`ifdef VGA_TIMING_FRAME_CNT_EN
    cmp({tag, ".frameCount"}, g.fc, e.fc);
`endif
  endtask
  task automatic check_cycle();
    check("dflt", get(0), model(640, 16, 96, 48, 480, 10, 2, 33, n));
    check("small", get(1), model(SW, SHF, SHS, SHB, SH, SVF, SVS, SVB, n));
  endtask
  task automatic step();
    @(posedge clk25);
    #1;
    n++;
    check_cycle();
  endtask
  task automatic pulse_reset(int hold);
    #2 rst_n = 1'b0;
    #1 n = 0;
    cmp("rst.x", x_a, 0);
    cmp("rst.y", y_a, 0);
    cmp("rst.active", act_a, 1);
    cmp("rst.hSync", hs_a, 1);
    cmp("rst.vSync", vs_a, 1);
    cmp("rst.screenEnd", se_a, 0);
    check_cycle();
    repeat (hold) begin
      @(posedge clk25);
      #1 check_cycle();
    end
    rst_n = 1'b1;
  endtask
  vec_t vec[23];
  initial begin
    int cnt;
    vec = '{
      '{0, 0, 0, 0, 1, 1, 1, 0},     '{1, 0, 1, 0, 1, 1, 1, 0},
      '{59, 1, 0, 0, 0, 1, 1, 0},    '{60, 1, 0, 0, 0, 1, 1, 1},
      '{61, 1, 0, 0, 0, 1, 1, 0},    '{75, 1, 0, 0, 0, 1, 0, 0},
      '{104, 1, 0, 0, 0, 1, 0, 0},   '{105, 1, 0, 0, 0, 1, 1, 0},
      '{120, 1, 0, 0, 1, 1, 1, 0},   '{124, 1, 4, 0, 1, 1, 1, 0},
      '{131, 1, 0, 0, 0, 0, 1, 0},   '{180, 1, 0, 0, 0, 1, 1, 1},
      '{639, 0, 639, 0, 1, 1, 1, 0}, '{640, 0, 0, 0, 0, 1, 1, 0},
      '{655, 0, 0, 0, 0, 1, 1, 0},   '{656, 0, 0, 0, 0, 0, 1, 0},
      '{751, 0, 0, 0, 0, 0, 1, 0},   '{752, 0, 0, 0, 0, 1, 1, 0},
      '{799, 0, 0, 0, 0, 1, 1, 0},   '{800, 0, 0, 1, 1, 1, 1, 0},
      '{801, 0, 1, 1, 1, 1, 1, 0},   '{1456, 0, 0, 0, 0, 0, 1, 0},
      '{1700, 0, 100, 2, 1, 1, 1, 0}
    };
    #1 check_cycle();
    repeat (3) begin
      @(posedge clk25);
      #1 check_cycle();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      out_t g;
      while (n < vec[i].cyc) step();
      g = get(vec[i].s);
      cmp($sformatf("vec%0d.x", i), g.x, vec[i].x);
      cmp($sformatf("vec%0d.y", i), g.y, vec[i].y);
      cmp($sformatf("vec%0d.active", i), g.act, vec[i].act);
      cmp($sformatf("vec%0d.hSync", i), g.hs, vec[i].hs);
      cmp($sformatf("vec%0d.vSync", i), g.vs, vec[i].vs);
      cmp($sformatf("vec%0d.screenEnd", i), g.se, vec[i].se);
    end
    cnt = 0;
    repeat (120) begin
      step();
      cnt += int'(se_b);
    end
    cmp("small.strobes_per_frame", cnt, 1);
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(500, 3000)) step();
      pulse_reset($urandom_range(0, 2));
    end
    while (n < 60) step();
    cmp("small.se_after_reset", se_b, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    while (n < 301) step();
    cmp("small.fc_3frames", fc_b, 3);
    while (n < 30660) step();
    cmp("small.fc_255", fc_b, 255);
    step();
    cmp("small.fc_wrap", fc_b, 0);
`else
    repeat (2000) step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
